// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the dmem loader: default memory geometry and FSM states.
package dmem_loader_pkg;

    localparam int LD_DATA_W = 32;
    localparam int LD_DEPTH  = 256;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_FIN
    } ld_state_e;

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// Big-endian byte-to-word assembler with a strobe on the byte that completes a word.
module dmem_loader_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              done_o
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign last   = (cnt_q == CNT_W'(NB - 1));
    assign done_o = en_i && last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // word_o already includes the byte on the input, so the completed word is
    // available in the same cycle as done_o.
    if (NB > 1) begin : g_multi
        logic [DATA_W-9:0] shift_q, shift_d;

        assign word_o = {shift_q, byte_i};

        always_comb begin
            shift_d = shift_q;
            if (clr_i) begin
                shift_d = '0;
            end else if (en_i) begin
                shift_d = word_o[DATA_W-9:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q <= '0;
            end else begin
                shift_q <= shift_d;
            end
        end
    end else begin : g_single
        assign word_o = byte_i;
    end

endmodule

// File: rtl/dmem_loader.sv
// Streams big-endian words from a byte channel into dmem; passes CPU accesses through when idle.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int DATA_W = LD_DATA_W,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = LD_DEPTH,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic              cpu_we,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int AXW = ADDR_W + 1;

    ld_state_e         state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              ovf_q, ovf_d;
    logic              wr_we_q, wr_we_d;
    logic [ADDR_W-1:0] wr_a_q, wr_a_d;
    logic [DATA_W-1:0] wr_wd_q, wr_wd_d;

    logic              accept;
    logic              pk_clr;
    logic              pk_en;
    logic [DATA_W-1:0] pk_word;
    logic              pk_done;
    logic [AXW-1:0]    addr_x;

    assign accept = in_valid && in_ready;
    assign pk_en  = accept && (state_q == LD_DATA);
    assign addr_x = AXW'(BASE) + AXW'(wcnt_q);

    dmem_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (pk_clr),
        .en_i   (pk_en),
        .byte_i (in_data),
        .word_o (pk_word),
        .done_o (pk_done)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        ovf_d    = ovf_q;
        wr_we_d  = 1'b0;
        wr_a_d   = wr_a_q;
        wr_wd_d  = wr_wd_q;
        pk_clr   = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (load_req) begin
                    state_d = LD_LEN_HI;
                    ovf_d   = 1'b0;
                end
            end
            LD_LEN_HI: begin
                in_ready = 1'b1;
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    len_d   = {len_hi_q, in_data};
                    wcnt_d  = '0;
                    pk_clr  = 1'b1;
                    state_d = (len_d == 16'd0) ? LD_FIN : LD_DATA;
                end
            end
            LD_DATA: begin
                in_ready = 1'b1;
                if (pk_done) begin
                    // Out-of-range words are still consumed and counted, just not written.
                    wr_a_d  = addr_x[ADDR_W-1:0];
                    wr_wd_d = pk_word;
                    if (addr_x >= AXW'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_we_d = 1'b1;
                    end
                    wcnt_d = wcnt_q + 16'd1;
                    if (wcnt_q == len_q - 16'd1) begin
                        state_d = LD_FIN;
                    end
                end
            end
            LD_FIN: begin
                done    = 1'b1;
                state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LD_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
            wr_we_q  <= 1'b0;
            wr_a_q   <= '0;
            wr_wd_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            ovf_q    <= ovf_d;
            wr_we_q  <= wr_we_d;
            wr_a_q   <= wr_a_d;
            wr_wd_q  <= wr_wd_d;
        end
    end

    assign busy      = (state_q != LD_IDLE);
    assign cpu_stall = busy;
    assign ovf       = ovf_q;

    always_comb begin
        if (busy || wr_we_q) begin
            mem_a  = wr_a_q;
            mem_wd = wr_wd_q;
            mem_we = wr_we_q;
        end else begin
            mem_a  = cpu_a;
            mem_wd = cpu_wd;
            mem_we = cpu_we;
        end
    end

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader: pass-through, loads with and without gaps, overflow, mid-session reset.
module tb_dmem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [15:0] cpu_a;
    logic [31:0] cpu_wd;
    logic        cpu_we;

    logic        in_ready, cpu_stall, mem_we, busy, done, ovf;
    logic [15:0] mem_a;
    logic [31:0] mem_wd;

    logic        in_ready2, cpu_stall2, mem_we2, busy2, done2, ovf2;
    logic [15:0] mem_a2;
    logic [31:0] mem_wd2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] log_a[$];
    logic [31:0] log_d[$];
    logic [15:0] log2_a[$];
    logic [31:0] log2_d[$];
    logic [31:0] model [256];
    int          done_cnt;
    logic        prev_done;
    logic        busy_after_done;
    logic        busy_at_done;
    logic        ovf2_at_done;

    dmem_loader u_dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
        .cpu_we(cpu_we), .cpu_stall(cpu_stall), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_we(mem_we), .busy(busy), .done(done), .ovf(ovf)
    );

    dmem_loader #(.DEPTH(2), .BASE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready2), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
        .cpu_we(cpu_we), .cpu_stall(cpu_stall2), .mem_a(mem_a2), .mem_wd(mem_wd2),
        .mem_we(mem_we2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            log_a.push_back(mem_a);
            log_d.push_back(mem_wd);
            if (mem_a < 16'd256) model[mem_a[7:0]] = mem_wd;
        end
        if (mem_we2) begin
            log2_a.push_back(mem_a2);
            log2_d.push_back(mem_wd2);
        end
        if (prev_done) busy_after_done = busy;
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
        if (done2) ovf2_at_done = ovf2;
        prev_done = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); log2_a.delete(); log2_d.delete();
        done_cnt = 0; busy_after_done = 1'b1; busy_at_done = 1'b0; ovf2_at_done = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) step();
        if (busy) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle timeout: busy=%0b required 0", busy);
        end
        step();
    endtask

    task automatic test_reset();
        n_tests++;
        if ({busy, done, ovf, in_ready, mem_we, cpu_stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/done/ovf/in_ready/mem_we/stall=%06b required 000000",
                     {busy, done, ovf, in_ready, mem_we, cpu_stall});
        end
    endtask

    task automatic test_passthrough();
        cpu_a = 16'd5; cpu_wd = 32'h12345678; cpu_we = 1'b1;
        #1;
        n_tests++;
        if (mem_a !== 16'd5 || mem_wd !== 32'h12345678 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL passthrough: a=%0d wd=%08h we=%0b required a=5 wd=12345678 we=1", mem_a, mem_wd, mem_we);
        end
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL passthrough_idle: busy=%0b in_ready=%0b required 0 0", busy, in_ready);
        end
        cpu_we = 1'b0;
        step();
    endtask

    task automatic check_two_words(input string tag);
        n_tests++;
        if (log_a.size() != 2) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d required 2", tag, log_a.size());
        end else begin
            n_tests++;
            if (log_a[0] !== 16'd0 || log_d[0] !== 32'h070a0001 || log_a[1] !== 16'd1 || log_d[1] !== 32'h00020102) begin
                n_fail++;
                $display("FAIL %s_writes: got a=%0d wd=%08h, a=%0d wd=%08h required 0/070a0001, 1/00020102",
                         tag, log_a[0], log_d[0], log_a[1], log_d[1]);
            end
        end
        n_tests++;
        if (done_cnt != 1 || busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: pulses=%0d busy_at_done=%0b busy_after=%0b required 1 1 0",
                     tag, done_cnt, busy_at_done, busy_after_done);
        end
    endtask

    task automatic test_load_continuous();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'h07, 8'h0a, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h02};
        clear_logs();
        pulse_load();
        for (int i = 0; i < 10; i++) send_byte(s[i]);
        wait_idle();
        check_two_words("cont");
        n_tests++;
        if (model[0] !== 32'h070a0001 || model[1] !== 32'h00020102) begin
            n_fail++;
            $display("FAIL cont_model_dmem: m0=%08h m1=%08h required 070a0001 00020102", model[0], model[1]);
        end
    endtask

    task automatic test_load_toggle();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'h07, 8'h0a, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h02};
        int ready_low = 0;
        clear_logs();
        pulse_load();
        cpu_a = 16'h0077; cpu_wd = 32'hdeadbeef; cpu_we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_byte(s[i]);
            if (i < 9) begin
                step();
                if (i >= 1 && !in_ready) ready_low++;
            end
        end
        cpu_we = 1'b0;
        wait_idle();
        check_two_words("toggle");
        n_tests++;
        if (ready_low != 0) begin
            n_fail++;
            $display("FAIL toggle_in_ready: low cycles in DATA=%0d required 0", ready_low);
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        pulse_load();
        send_byte(8'h00);
        send_byte(8'h00);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_done: done=%0b required 1", done);
        end
        wait_idle();
        n_tests++;
        if (log_a.size() != 0 || ovf !== 1'b0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_len_nowrite: writes=%0d ovf=%0b done_pulses=%0d required 0 0 1",
                     log_a.size(), ovf, done_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s [14] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc};
        clear_logs();
        pulse_load();
        for (int i = 0; i < 14; i++) send_byte(s[i]);
        wait_idle();
        n_tests++;
        if (log2_a.size() != 1) begin
            n_fail++;
            $display("FAIL ovf_write_count: got %0d required 1", log2_a.size());
        end else begin
            n_tests++;
            if (log2_a[0] !== 16'd1 || log2_d[0] !== 32'h11223344) begin
                n_fail++;
                $display("FAIL ovf_write: a=%0d wd=%08h required a=1 wd=11223344", log2_a[0], log2_d[0]);
            end
        end
        n_tests++;
        if (ovf2_at_done !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flag: ovf_at_done=%0b busy=%0b required 1 0", ovf2_at_done, busy2);
        end
        pulse_load();
        n_tests++;
        if (ovf2 !== 1'b0 || in_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%0b in_ready=%0b required 0 1", ovf2, in_ready2);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [7:0] s [7] = '{8'h00, 8'h02, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5};
        logic [7:0] r [6] = '{8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef};
        clear_logs();
        pulse_load();
        for (int i = 0; i < 7; i++) send_byte(s[i]);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: busy=%0b in_ready=%0b mem_we=%0b required 0 0 0", busy, in_ready, mem_we);
        end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        n_tests++;
        if (log_a.size() != 1 || log_a[0] !== 16'd0 || log_d[0] !== 32'ha1a2a3a4) begin
            n_fail++;
            $display("FAIL rst_mid_writes: count=%0d first a=%0d wd=%08h required 1 0 a1a2a3a4",
                     log_a.size(), log_a[0], log_d[0]);
        end
        pulse_load();
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_restart: busy=%0b in_ready=%0b required 1 1", busy, in_ready);
        end
        for (int i = 0; i < 6; i++) send_byte(r[i]);
        wait_idle();
        n_tests++;
        if (log_a.size() != 2 || log_a[1] !== 16'd0 || log_d[1] !== 32'hdeadbeef) begin
            n_fail++;
            $display("FAIL rst_mid_reload: count=%0d last a=%0d wd=%08h required 2 0 deadbeef",
                     log_a.size(), log_a[log_a.size()-1], log_d[log_d.size()-1]);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0;
        cpu_a = '0; cpu_wd = '0; cpu_we = 1'b0;
        prev_done = 1'b0;
        clear_logs();
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_passthrough();
        test_load_continuous();
        test_load_toggle();
        test_zero_len();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
